// File: rtl/mux8way_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8way_rr_arbiter
//
// Merges eight valid/ready source channels onto one registered output channel
// using round-robin arbitration. The output carries the winning word and the
// 3-bit index of the channel it came from, so a downstream 8-way demux can
// route the word back to its origin.
//
// The output register is a two-state (EMPTY/FULL) stage. It accepts a new word
// whenever it is empty or is draining this cycle, which gives one word per cycle.
//
// Parameters:
//   WIDTH      data word width per channel
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   [7:0]        bit k: channel k presents a word
//   in_data    [8*WIDTH-1:0] channel k word at bits [k*WIDTH +: WIDTH]
//   in_last    [7:0]        bit k: channel k's word ends its packet
//                           (present only with ARB_LOCK_EN)
//   in_ready   [7:0]        bit k: channel k word accepted this cycle (comb)
//   out_valid               output register holds a word
//   out_data   [WIDTH-1:0]  registered word
//   out_sel    [2:0]        index of the channel that supplied out_data
//   out_ready               consumer accepts the output word this cycle
//
// Optional feature (macro ARB_LOCK_EN):
//   Adds in_last. A grant whose word is not the last of its packet locks the
//   arbiter to that channel until a word with in_last set is accepted.
// -----------------------------------------------------------------------------
module mux8way_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_valid,
    input  logic [8*WIDTH-1:0]   in_data,
`ifdef ARB_LOCK_EN
    input  logic [7:0]           in_last,
`endif
    output logic [7:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_sel,
    input  logic                 out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [2:0]         sel_q, sel_d;
`ifdef ARB_LOCK_EN
    logic               lock_q, lock_d;
`endif

    logic               load_en;
    logic [7:0]         elig;
    logic               gnt_any;
    logic [2:0]         gnt_idx;
    logic [2:0]         scan_idx;
    logic               take;

    assign load_en = (state_q == EMPTY) | out_ready;

    // While locked, ptr_q still points at the owning channel, so masking the
    // requests down to that one bit keeps every other channel out.
`ifdef ARB_LOCK_EN
    assign elig = lock_q ? (in_valid & (8'b1 << ptr_q)) : in_valid;
`else
    assign elig = in_valid;
`endif

    // Scan from the farthest offset back towards ptr_q so the last hit written
    // is the one closest to the pointer, i.e. the round-robin winner.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            scan_idx = ptr_q + 3'(i);
            if (elig[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Reset gates the handshake combinationally so no source sees a grant
    // while the register is being cleared.
    assign take     = load_en & gnt_any & ~reset;
    assign in_ready = take ? (8'b1 << gnt_idx) : 8'h00;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= 3'd0;
            data_q  <= '0;
            sel_q   <= 3'd0;
`ifdef ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifdef ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
`ifdef ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            EMPTY: begin
                if (take) state_d = FULL;
            end
            FULL: begin
                if (take)           state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (take) begin
            data_d = in_data[gnt_idx*WIDTH +: WIDTH];
            sel_d  = gnt_idx;
            ptr_d  = gnt_idx + 3'd1;
`ifdef ARB_LOCK_EN
            // A mid-packet grant parks the pointer on the owner; the rotation
            // happens only when the packet's last word goes through.
            if (in_last[gnt_idx]) begin
                lock_d = 1'b0;
            end else begin
                lock_d = 1'b1;
                ptr_d  = gnt_idx;
            end
`endif
        end
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = data_q;
        out_sel   = sel_q;
    end

endmodule

// File: tb/tb_mux8way_rr_arbiter.sv
module tb_mux8way_rr_arbiter;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      in_valid;
    logic [8*W-1:0]  in_data;
    logic [7:0]      in_last;
    logic [7:0]      in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [2:0]      out_sel;
    logic            out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard of expected {data, sel}
    logic [W+2:0] sb[$];

    // reference model state
    int   m_ptr  = 0;
    bit   m_valid = 0;
    bit   m_lock = 0;

    mux8way_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef ARB_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_gnt(input logic [7:0] v, input int p);
        for (int i = 0; i < 8; i++) begin
            if (v[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    // One clock: evaluate the model and compare at the falling edge, then
    // return 1 time unit after the next rising edge for the caller to drive.
    task automatic cycle();
        logic [7:0]   elig;
        logic [7:0]   exp_rdy;
        logic [W+2:0] e;
        bit           load;
        int           g;
        @(negedge clk);
        if (reset) begin
            m_ptr   = 0;
            m_valid = 0;
            m_lock  = 0;
            sb.delete();
        end else begin
            load = !m_valid || out_ready;
            elig = m_lock ? (in_valid & (8'b1 << m_ptr)) : in_valid;
            g    = load ? model_gnt(elig, m_ptr) : -1;
            exp_rdy = (g >= 0) ? 8'(32'd1 << g) : 8'h00;
            chk("in_ready", {24'd0, in_ready}, {24'd0, exp_rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", {16'd0, out_data}, {16'd0, e[W+2:3]});
                    chk("sb_sel", {29'd0, out_sel}, {29'd0, e[2:0]});
                end
            end
            if (g >= 0) begin
                sb.push_back({in_data[g*W +: W], 3'(g)});
                m_valid = 1;
`ifdef ARB_LOCK_EN
                if (in_last[g]) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % 8;
                end else begin
                    m_lock = 1;
                    m_ptr  = g;
                end
`else
                m_ptr = (g + 1) % 8;
`endif
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 8'hFF;
        in_last   = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) in_data[k*W +: W] = 16'h0010 + 16'(k);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
        chk("rst_in_ready", {24'd0, in_ready}, 32'd0);
        cycle();
        cycle();
        reset = 1'b0;

        // round robin with every channel requesting
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("rr_sel", {29'd0, out_sel}, i % 8);
            chk("rr_data", {16'd0, out_data}, 32'h10 + (i % 8));
        end
        in_valid = 8'h00;
        cycle();

        // single channel 5
        in_valid = 8'h20;
        in_data[5*W +: W] = 16'hBEEF;
        cycle();
        in_valid = 8'h00;
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_sel", {29'd0, out_sel}, 32'd5);
        chk("single_data", {16'd0, out_data}, 32'hBEEF);
        cycle();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_sel_hold", {29'd0, out_sel}, 32'd5);
        in_data[5*W +: W] = 16'h0015;

        // backpressure: load ch2 (ptr -> 3), then stall with ch0/ch7 requesting
        in_valid = 8'h04;
        cycle();
        in_valid  = 8'h81;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_sel", {29'd0, out_sel}, 32'd2);
            chk("stall_data", {16'd0, out_data}, 32'h12);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_grant_sel", {29'd0, out_sel}, 32'd7);
        in_valid = 8'h00;
        cycle();

        // wrap: ch6 sets ptr to 7, then ch0/ch1 alternate
        in_valid = 8'h40;
        cycle();
        in_valid = 8'h03;
        cycle();
        chk("wrap_sel0", {29'd0, out_sel}, 32'd0);
        cycle();
        chk("wrap_sel1", {29'd0, out_sel}, 32'd1);
        cycle();
        chk("wrap_sel2", {29'd0, out_sel}, 32'd0);
        in_valid = 8'h00;
        cycle();

        // asynchronous reset mid-cycle while holding a word
        in_valid  = 8'h08;
        out_ready = 1'b0;
        cycle();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {16'd0, out_data}, 32'd0);
        chk("arst_out_sel", {29'd0, out_sel}, 32'd0);
        chk("arst_in_ready", {24'd0, in_ready}, 32'd0);
        cycle();
        reset     = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        cycle();
        chk("post_rst_sel", {29'd0, out_sel}, 32'd0);
        in_valid = 8'h00;
        cycle();

`ifdef ARB_LOCK_EN
        // packet lock: ch0 sends three words, ch2 must wait for the last one
        reset = 1'b1;
        cycle();
        reset    = 1'b0;
        in_valid = 8'h05;
        in_last  = 8'h00;
        cycle();
        chk("lock_sel_a", {29'd0, out_sel}, 32'd0);
        cycle();
        chk("lock_sel_b", {29'd0, out_sel}, 32'd0);
        in_last = 8'h01;
        cycle();
        chk("lock_sel_c", {29'd0, out_sel}, 32'd0);
        in_last = 8'h04;
        cycle();
        chk("lock_sel_d", {29'd0, out_sel}, 32'd2);
        in_valid = 8'h00;
        in_last  = 8'hFF;
        cycle();
`endif

        cycle();
        chk("sb_left", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
